// File: rtl/uart_pkt_pkg.sv
// rtl/uart_pkt_pkg.sv - shared states, command and error constants for the packet controller
//
// Purpose: common definitions for uart_pkt_ctrl and its helpers.
// Contents: parser state encoding, command bytes, error codes, command helpers.

package uart_pkt_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CMD     = 3'd1,
      S_LENH    = 3'd2,
      S_LENL    = 3'd3,
      S_PAYLOAD = 3'd4,
      S_CHK     = 3'd5
   } pkt_state_e;

   localparam logic [7:0] CMD_FRAME  = 8'h01;
   localparam logic [7:0] CMD_APPEND = 8'h02;
   localparam logic [7:0] CMD_PING   = 8'h03;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_CHK  = 2'b01;
   localparam logic [1:0] ERR_TMO  = 2'b10;
   localparam logic [1:0] ERR_CMD  = 2'b11;

   function automatic logic is_known_cmd(input logic [7:0] cmd);
      return (cmd == CMD_FRAME) || (cmd == CMD_APPEND) || (cmd == CMD_PING);
   endfunction

   // Only frame-start and append commands put their payload into the frame buffer.
   function automatic logic writes_payload(input logic [7:0] cmd);
      return (cmd == CMD_FRAME) || (cmd == CMD_APPEND);
   endfunction

endpackage

// File: rtl/uart_pkt_ctrl_if.sv
// rtl/uart_pkt_ctrl_if.sv - byte-in / frame-buffer-write / status bundle of the packet controller
//
// Purpose: groups the receiver byte strobe, the frame-buffer write port and the packet
// status outputs of uart_pkt_ctrl.
// Signals:
//   i_rx_data  [7:0]            received byte, valid while i_rx_done is high
//   i_rx_done                   single-cycle byte strobe
//   o_wr_en / o_wr_addr / o_wr_data  frame-buffer write port
//   o_cmd      [7:0]            command of current/last packet
//   o_pkt_ok / o_pkt_err        one-cycle result pulses
//   o_err_code [1:0]            last error code
//   o_busy                      parser is inside a packet
// Modports: slave = controller side, master = byte source / status consumer side.

interface uart_pkt_ctrl_if #(
   parameter int ADDR_WIDTH = 16
);
   logic [7:0]            i_rx_data;
   logic                  i_rx_done;
   logic                  o_wr_en;
   logic [ADDR_WIDTH-1:0] o_wr_addr;
   logic [7:0]            o_wr_data;
   logic [7:0]            o_cmd;
   logic                  o_pkt_ok;
   logic                  o_pkt_err;
   logic [1:0]            o_err_code;
   logic                  o_busy;

   modport slave (
      input  i_rx_data, i_rx_done,
      output o_wr_en, o_wr_addr, o_wr_data, o_cmd, o_pkt_ok, o_pkt_err, o_err_code, o_busy
   );

   modport master (
      output i_rx_data, i_rx_done,
      input  o_wr_en, o_wr_addr, o_wr_data, o_cmd, o_pkt_ok, o_pkt_err, o_err_code, o_busy
   );
endinterface

// File: rtl/pkt_timeout_cnt.sv
// rtl/pkt_timeout_cnt.sv - inter-byte timeout down-counter with clear and expiry pulse
//
// Purpose: measures the gap between bytes inside a packet.
// Ports:
//   i_clk_sys  clock
//   i_rst_n    asynchronous active-low reset
//   i_en       counter runs (parser not idle)
//   i_clr      byte strobe; reloads the full interval, wins over expiry
//   o_expire   combinational pulse: CYCLES cycles elapsed since the last clear

module pkt_timeout_cnt #(
   parameter int unsigned CYCLES = 100000
) (
   input  logic i_clk_sys,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_expire
);

   localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

   logic [CW-1:0] cnt_q;

   // Clear is checked before enable so the header byte that leaves idle arms
   // the counter for the first gap.
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else if (i_clr) begin
         cnt_q <= LOAD;
      end else if (!i_en) begin
         cnt_q <= '0;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign o_expire = i_en && !i_clr && (cnt_q == '0);

endmodule

// File: rtl/uart_pkt_ctrl.sv
// rtl/uart_pkt_ctrl.sv - framed packet parser between UART receiver and frame buffer
//
// Purpose: parses HDR, CMD, LEN_H, LEN_L, payload, CHK packets from a byte strobe,
// streams payload bytes into the frame buffer and reports packet results.
// Parameters: CLK_FRE (MHz), TIMEOUT_US (max inter-byte gap), ADDR_WIDTH, HDR_BYTE.
// Ports:
//   i_clk_sys  system clock
//   i_rst_n    asynchronous active-low reset
//   bus        uart_pkt_ctrl_if.slave: byte input, write port, status outputs

module uart_pkt_ctrl
   import uart_pkt_pkg::*;
#(
   parameter int         CLK_FRE    = 50,
   parameter int         TIMEOUT_US = 2000,
   parameter int         ADDR_WIDTH = 16,
   parameter logic [7:0] HDR_BYTE   = 8'hA5
) (
   input  logic            i_clk_sys,
   input  logic            i_rst_n,
   uart_pkt_ctrl_if.slave  bus
);

   pkt_state_e            state_q, state_d;
   logic [7:0]            cmd_q, cmd_d;
   logic [7:0]            len_hi_q, len_hi_d;
   logic [7:0]            sum_q, sum_d;
   logic [15:0]           remain_q, remain_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]            wr_data_q, wr_data_d;
   logic                  wr_en_q, wr_en_d;
   logic                  ok_q, ok_d;
   logic                  err_q, err_d;
   logic [1:0]            code_q, code_d;
   logic [15:0]           len_w;
   logic                  busy;
   logic                  tmo_expire;

   assign busy  = (state_q != S_IDLE);
   assign len_w = {len_hi_q, bus.i_rx_data};

   pkt_timeout_cnt #(
      .CYCLES (CLK_FRE * TIMEOUT_US)
   ) u_tmo (
      .i_clk_sys (i_clk_sys),
      .i_rst_n   (i_rst_n),
      .i_en      (busy),
      .i_clr     (bus.i_rx_done),
      .o_expire  (tmo_expire)
   );

   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      len_hi_d  = len_hi_q;
      sum_d     = sum_q;
      remain_d  = remain_q;
      ptr_d     = ptr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      ok_d      = 1'b0;
      err_d     = 1'b0;
      code_d    = code_q;

      // A byte arriving on the expiry cycle is processed; the timeout is dropped.
      if (bus.i_rx_done) begin
         case (state_q)
            S_IDLE: begin
               if (bus.i_rx_data == HDR_BYTE) begin
                  state_d = S_CMD;
               end
            end
            S_CMD: begin
               cmd_d   = bus.i_rx_data;
               sum_d   = bus.i_rx_data;
               state_d = S_LENH;
            end
            S_LENH: begin
               len_hi_d = bus.i_rx_data;
               sum_d    = sum_q + bus.i_rx_data;
               state_d  = S_LENL;
            end
            S_LENL: begin
               sum_d    = sum_q + bus.i_rx_data;
               remain_d = len_w;
               if (cmd_q == CMD_FRAME) begin
                  ptr_d = '0;
               end
               state_d = (len_w == 16'd0) ? S_CHK : S_PAYLOAD;
            end
            S_PAYLOAD: begin
               sum_d    = sum_q + bus.i_rx_data;
               remain_d = remain_q - 16'd1;
               // Writes are speculative: a later bad checksum leaves them in place.
               if (writes_payload(cmd_q)) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = bus.i_rx_data;
                  ptr_d     = ptr_q + ADDR_WIDTH'(1);
               end
               if (remain_q == 16'd1) begin
                  state_d = S_CHK;
               end
            end
            S_CHK: begin
               state_d = S_IDLE;
               // Checksum failure outranks an unknown command.
               if (bus.i_rx_data != sum_q) begin
                  err_d  = 1'b1;
                  code_d = ERR_CHK;
               end else if (!is_known_cmd(cmd_q)) begin
                  err_d  = 1'b1;
                  code_d = ERR_CMD;
               end else begin
                  ok_d = 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end else if (tmo_expire) begin
         state_d = S_IDLE;
         err_d   = 1'b1;
         code_d  = ERR_TMO;
      end
   end

   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cmd_q     <= '0;
         len_hi_q  <= '0;
         sum_q     <= '0;
         remain_q  <= '0;
         ptr_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= ERR_NONE;
      end else begin
         cmd_q     <= cmd_d;
         len_hi_q  <= len_hi_d;
         sum_q     <= sum_d;
         remain_q  <= remain_d;
         ptr_q     <= ptr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         ok_q      <= ok_d;
         err_q     <= err_d;
         code_q    <= code_d;
      end
   end

   assign bus.o_wr_en    = wr_en_q;
   assign bus.o_wr_addr  = wr_addr_q;
   assign bus.o_wr_data  = wr_data_q;
   assign bus.o_cmd      = cmd_q;
   assign bus.o_pkt_ok   = ok_q;
   assign bus.o_pkt_err  = err_q;
   assign bus.o_err_code = code_q;
   assign bus.o_busy     = busy;

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// tb/tb_uart_pkt_ctrl.sv - self-checking bench for uart_pkt_ctrl

module tb_uart_pkt_ctrl;

   localparam int         CLK_FRE    = 50;
   localparam int         TIMEOUT_US = 1;
   localparam int         AW         = 8;
   localparam logic [7:0] HDR        = 8'hA5;
   localparam int         TMO        = CLK_FRE * TIMEOUT_US;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uart_pkt_ctrl_if #(.ADDR_WIDTH(AW)) ifc ();

   uart_pkt_ctrl #(
      .CLK_FRE    (CLK_FRE),
      .TIMEOUT_US (TIMEOUT_US),
      .ADDR_WIDTH (AW),
      .HDR_BYTE   (HDR)
   ) dut (
      .i_clk_sys (clk),
      .i_rst_n   (rst_n),
      .bus       (ifc)
   );

   int checks   = 0;
   int failures = 0;

   logic [7:0]    tx_q[$];
   bit            we_q[$];
   logic [AW-1:0] addr_q[$];
   bit            busy_q[$];
   logic [7:0]    pl_q[$];
   logic [7:0]    junk_q[$];

   int         model_ptr  = 0;
   logic [1:0] model_code = 2'b00;
   logic [7:0] model_cmd  = 8'h00;
   bit         exp_ok, exp_err;
   int         tot_wr = 0, tot_ok = 0, tot_err = 0;
   int         mon_wr = 0, mon_ok = 0, mon_err = 0;

   always @(negedge clk) begin
      if (ifc.o_wr_en === 1'b1)   mon_wr++;
      if (ifc.o_pkt_ok === 1'b1)  mon_ok++;
      if (ifc.o_pkt_err === 1'b1) mon_err++;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b, input bit we, input logic [AW-1:0] a, input bit busy);
      tx_q.push_back(b);
      we_q.push_back(we);
      addr_q.push_back(a);
      busy_q.push_back(busy);
   endtask

   // Builds the byte stream for one packet from junk_q/pl_q and predicts its effects.
   task automatic build_pkt(input logic [7:0] cmd, input int decl_len, input bit complete,
                            input bit corrupt);
      logic [7:0]    sum;
      logic [AW-1:0] base;
      bit            wr;
      int            n;
      tx_q.delete(); we_q.delete(); addr_q.delete(); busy_q.delete();
      foreach (junk_q[i]) push(junk_q[i], 1'b0, '0, 1'b0);
      n = pl_q.size();
      push(HDR, 1'b0, '0, 1'b1);
      push(cmd, 1'b0, '0, 1'b1);
      push(8'(decl_len >> 8), 1'b0, '0, 1'b1);
      push(8'(decl_len), 1'b0, '0, 1'b1);
      sum  = cmd + 8'(decl_len >> 8) + 8'(decl_len);
      wr   = (cmd == 8'h01) || (cmd == 8'h02);
      base = (cmd == 8'h01) ? '0 : AW'(model_ptr);
      for (int i = 0; i < n; i++) begin
         sum += pl_q[i];
         push(pl_q[i], wr, AW'(int'(base) + i), 1'b1);
      end
      if (wr) begin
         model_ptr = (int'(base) + n) % (1 << AW);
         tot_wr += n;
      end
      model_cmd = cmd;
      if (complete) begin
         push(corrupt ? (sum ^ 8'($urandom_range(1, 255))) : sum, 1'b0, '0, 1'b0);
         exp_ok  = 1'b0;
         exp_err = 1'b1;
         if (corrupt)                        model_code = 2'b01;
         else if (cmd < 8'h01 || cmd > 8'h03) model_code = 2'b11;
         else begin
            exp_ok  = 1'b1;
            exp_err = 1'b0;
         end
         tot_ok  += int'(exp_ok);
         tot_err += int'(exp_err);
      end
   endtask

   // Called at a falling edge; each byte is a one-cycle strobe, checked one cycle later.
   task automatic drive(input int gmin, input int gmax, input bit complete);
      int last;
      last = tx_q.size() - 1;
      for (int i = 0; i <= last; i++) begin
         ifc.i_rx_data = tx_q[i];
         ifc.i_rx_done = 1'b1;
         @(negedge clk);
         ifc.i_rx_done = 1'b0;
         check("wr_en", ifc.o_wr_en, we_q[i]);
         if (we_q[i]) begin
            check("wr_addr", ifc.o_wr_addr, addr_q[i]);
            check("wr_data", ifc.o_wr_data, tx_q[i]);
         end
         check("busy", ifc.o_busy, busy_q[i]);
         if (complete && i == last) begin
            check("pkt_ok", ifc.o_pkt_ok, exp_ok);
            check("pkt_err", ifc.o_pkt_err, exp_err);
            check("err_code", ifc.o_err_code, model_code);
            check("cmd", ifc.o_cmd, model_cmd);
         end
         if (i != last) repeat ($urandom_range(gmin, gmax)) @(negedge clk);
      end
   endtask

   task automatic settle();
      repeat (2) @(negedge clk);
      check("total_writes", mon_wr, tot_wr);
      check("total_ok", mon_ok, tot_ok);
      check("total_err", mon_err, tot_err);
      check("busy_after", ifc.o_busy, 1'b0);
   endtask

   initial begin
      int k;
      logic [7:0] c;
      ifc.i_rx_data = 8'h00;
      ifc.i_rx_done = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_wr_en", ifc.o_wr_en, 1'b0);
      check("rst_wr_addr", ifc.o_wr_addr, 0);
      check("rst_wr_data", ifc.o_wr_data, 0);
      check("rst_cmd", ifc.o_cmd, 0);
      check("rst_ok", ifc.o_pkt_ok, 1'b0);
      check("rst_err", ifc.o_pkt_err, 1'b0);
      check("rst_code", ifc.o_err_code, 0);
      check("rst_busy", ifc.o_busy, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // Frame start with three bytes, then append one.
      junk_q = {};
      pl_q = {8'h11, 8'h22, 8'h33};
      build_pkt(8'h01, 3, 1'b1, 1'b0);
      check("pkt1_chk_byte", tx_q[7], 8'h6A);
      drive(0, 2, 1'b1); settle();
      pl_q = {8'h44};
      build_pkt(8'h02, 1, 1'b1, 1'b0);
      check("pkt2_chk_byte", tx_q[5], 8'h47);
      drive(0, 2, 1'b1); settle();

      // Bad checksum: write still lands, error 01.
      pl_q = {8'h55};
      build_pkt(8'h01, 1, 1'b0, 1'b0);
      push(8'h00, 1'b0, '0, 1'b0);
      exp_ok = 1'b0; exp_err = 1'b1; model_code = 2'b01; tot_err++;
      drive(0, 2, 1'b1); settle();

      // Leading junk then an empty ping.
      junk_q = {8'h00, 8'h7F};
      pl_q = {};
      build_pkt(8'h03, 0, 1'b1, 1'b0);
      drive(0, 2, 1'b1); settle();
      junk_q = {};

      // Header then silence: timeout after exactly TMO cycles.
      pl_q = {};
      build_pkt(8'h01, 4, 1'b0, 1'b0);
      drive(0, 0, 1'b0);
      k = 0;
      while (ifc.o_pkt_err !== 1'b1 && k < 4 * TMO) begin
         @(negedge clk);
         k++;
      end
      check("tmo_latency", k, TMO);
      check("tmo_code", ifc.o_err_code, 2'b10);
      check("tmo_busy", ifc.o_busy, 1'b0);
      model_code = 2'b10; tot_err++;
      @(negedge clk);
      check("tmo_pulse_width", ifc.o_pkt_err, 1'b0);
      settle();

      // Pointer was reset by the frame header before the timeout.
      pl_q = {8'h9C, 8'h3E};
      build_pkt(8'h02, 2, 1'b1, 1'b0);
      drive(0, 2, 1'b1); settle();

      // Unknown command.
      pl_q = {};
      build_pkt(8'h09, 0, 1'b1, 1'b0);
      drive(0, 2, 1'b1); settle();

      // Header byte inside the payload is plain data.
      pl_q = {HDR, HDR, 8'h01};
      build_pkt(8'h02, 3, 1'b1, 1'b0);
      drive(0, 2, 1'b1); settle();

      // Gap of exactly the timeout interval: the byte wins.
      pl_q = {8'h12, 8'h34};
      build_pkt(8'h02, 2, 1'b1, 1'b0);
      drive(TMO - 1, TMO - 1, 1'b1); settle();

      // Address wrap: fill to the top, append two.
      pl_q = {};
      for (int i = 0; i < (1 << AW) - 1; i++) pl_q.push_back(8'($urandom));
      build_pkt(8'h01, (1 << AW) - 1, 1'b1, 1'b0);
      drive(0, 0, 1'b1); settle();
      pl_q = {8'hE1, 8'hE2};
      build_pkt(8'h02, 2, 1'b1, 1'b0);
      check("wrap_addr_hi", addr_q[4], (1 << AW) - 1);
      check("wrap_addr_lo", addr_q[5], 0);
      drive(0, 1, 1'b1); settle();

      // Randomized packets.
      for (int p = 0; p < 40; p++) begin
         junk_q = {};
         repeat ($urandom_range(0, 2)) begin
            c = 8'($urandom);
            junk_q.push_back((c == HDR) ? 8'h00 : c);
         end
         case ($urandom_range(0, 4))
            0:       c = 8'h01;
            1, 2:    c = 8'h02;
            3:       c = 8'h03;
            default: c = 8'($urandom_range(4, 255));
         endcase
         pl_q = {};
         repeat ($urandom_range(0, 6)) pl_q.push_back(8'($urandom));
         build_pkt(c, pl_q.size(), 1'b1, ($urandom_range(0, 3) == 0));
         drive(0, 4, 1'b1); settle();
      end
      junk_q = {};

      // Reset in the middle of a payload.
      pl_q = {8'hAA, 8'hBB};
      build_pkt(8'h01, 5, 1'b0, 1'b0);
      drive(0, 0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_wr_en", ifc.o_wr_en, 1'b0);
      check("mid_rst_wr_addr", ifc.o_wr_addr, 0);
      check("mid_rst_wr_data", ifc.o_wr_data, 0);
      check("mid_rst_cmd", ifc.o_cmd, 0);
      check("mid_rst_ok", ifc.o_pkt_ok, 1'b0);
      check("mid_rst_err", ifc.o_pkt_err, 1'b0);
      check("mid_rst_code", ifc.o_err_code, 0);
      check("mid_rst_busy", ifc.o_busy, 1'b0);
      model_ptr = 0; model_code = 2'b00; model_cmd = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (TMO + 10) @(negedge clk);
      settle();
      pl_q = {8'h77};
      build_pkt(8'h02, 1, 1'b1, 1'b0);
      drive(0, 2, 1'b1); settle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_pkt_ctrl.md
Name: uart_pkt_ctrl

Overview:
- Packet controller downstream of the UART receiver in the photo-frame datapath.
- Consumes the receiver's byte strobe (`o_rx_done` / `o_uart_data`) and parses framed packets: header, command, 16-bit length, payload, checksum.
- Streams payload bytes as single-cycle writes into the frame-buffer write port.
- Reports packet completion and errors: checksum, unknown command, inter-byte timeout.

Parameters:
- CLK_FRE, 50, system clock in MHz.
- TIMEOUT_US, 2000, max gap between bytes inside a packet, in µs.
- ADDR_WIDTH, 16, frame-buffer address width.
- HDR_BYTE, 8'hA5, packet start marker.

Ports:
- i_clk_sys  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_rx_data  in  8  received byte, valid while i_rx_done is high.
- i_rx_done  in  1  single-cycle byte strobe from the UART receiver.
- o_wr_en  out  1  frame-buffer write strobe, one cycle per payload byte.
- o_wr_addr  out  ADDR_WIDTH  write address.
- o_wr_data  out  8  write data.
- o_cmd  out  8  command of the current/last packet.
- o_pkt_ok  out  1  one-cycle pulse: packet accepted.
- o_pkt_err  out  1  one-cycle pulse: packet rejected.
- o_err_code  out  2  01 checksum, 10 timeout, 11 unknown cmd; holds until next o_pkt_ok/o_pkt_err.
- o_busy  out  1  high in any state other than S_IDLE.

Behaviour:
- One clock (i_clk_sys); reset is asynchronous and active-low (i_rst_n).
- Reset values: all outputs 0, state S_IDLE, write pointer 0, checksum 0, timeout counter 0.
- Packet format: HDR, CMD, LEN_H, LEN_L, LEN payload bytes, CHK.
  - CHK = (CMD + LEN_H + LEN_L + all payload bytes) mod 256.
- Each high cycle of i_rx_done is exactly one byte. All actions are registered; the response appears the cycle after the strobe.
- States and transitions, on i_rx_done:
  - S_IDLE: byte == HDR_BYTE → S_CMD; any other byte is silently dropped, no error.
  - S_CMD: latch o_cmd, sum := byte → S_LENH.
  - S_LENH: latch len[15:8], add to sum → S_LENL.
  - S_LENL: latch len[7:0], add to sum → S_PAYLOAD if len != 0, else S_CHK.
  - S_PAYLOAD: add byte to sum, decrement remaining count; at 0 → S_CHK.
  - S_CHK: compare byte with sum, then → S_IDLE.
- Commands:
  - 0x01 (frame start): write pointer := 0 on leaving S_LENL; payload bytes are written.
  - 0x02 (append): payload bytes are written from the current pointer.
  - 0x03 (no-op/ping): payload is consumed, nothing written.
  - Any other value: payload is consumed, nothing written, error 11 at S_CHK.
- Writes (cmd 0x01/0x02):
  - Each payload byte gives o_wr_en = 1 for one cycle the clock after its strobe.
  - o_wr_addr = pointer, o_wr_data = byte; pointer increments after each write.
  - Pointer wraps from 2^ADDR_WIDTH−1 to 0.
  - Writes are speculative; a later checksum failure does not roll them back.
- Packet result at S_CHK:
  - Checksum match and known cmd → o_pkt_ok pulse.
  - Checksum mismatch → o_pkt_err, code 01. Checksum has priority over unknown cmd.
  - Unknown cmd with correct checksum → o_pkt_err, code 11.
- Timeout:
  - Counter runs in every state except S_IDLE and clears on each i_rx_done.
  - Reaching CLK_FRE*TIMEOUT_US−1 → o_pkt_err, code 10, state S_IDLE. Pointer is kept.
  - If the timeout limit and i_rx_done coincide, the byte wins: it is processed and the counter clears.
- A HDR_BYTE arriving mid-packet is treated as ordinary data; there is no resync.
- Asserting reset mid-packet aborts the packet immediately with no error pulse.

Decomposition:
- Shared package uart_pkt_pkg holds:
  - state encodings S_IDLE..S_CHK;
  - command constants CMD_FRAME = 8'h01, CMD_APPEND = 8'h02, CMD_PING = 8'h03;
  - error codes ERR_CHK, ERR_TMO, ERR_CMD.
- One natural sub-module: pkt_timeout_cnt, a parameterised down-counter with clear and an expiry pulse.

Test Plan:
- A5 01 00 03 11 22 33 CHK=0x6A → three writes: addr 0/1/2, data 11/22/33; o_pkt_ok pulse; o_err_code unchanged.
- Then A5 02 00 01 44 CHK=0x47 → one write at addr 3, data 44; o_pkt_ok pulse.
- A5 01 00 01 55 CHK=0x00 (bad) → write at addr 0 occurs; o_pkt_err with code 01.
- 00 7F A5 03 00 00 03 → leading bytes ignored; no writes; o_pkt_ok pulse; o_cmd = 03.
- A5 01 00 04 then silence beyond TIMEOUT (bench uses TIMEOUT_US = 1) → o_pkt_err, code 10, o_busy falls. Next valid packet is accepted.
- A5 09 00 00 09 → o_pkt_err, code 11, no writes.
- Pointer at FFFF with cmd 02, 2 bytes → writes at FFFF then 0000.
- Reset asserted mid-payload → all outputs 0 asynchronously; no pulses after release.
